// File: rtl/fpu_pkg.sv
// Shared floating-point constants, the float-to-int stage payload and the S1 unpack/align helper.
package fpu_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned INT_W = 32;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned ALN_W = INT_W + SIG_W;

  localparam logic [EXP_W-1:0] EXP_BIAS = 8'd127;
  localparam logic [EXP_W-1:0] EXP_INF  = 8'd255;
  localparam logic [INT_W-1:0] INT_MAX  = 32'h7FFF_FFFF;
  localparam logic [INT_W-1:0] INT_MIN  = 32'h8000_0000;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,
    CLS_ZERO   = 2'd1,
    CLS_SAT    = 2'd2
  } ftoi_cls_e;

  typedef struct packed {
    logic             sign;
    logic [INT_W-1:0] mag;
    logic             guard;
    logic             sticky;
    ftoi_cls_e        cls;
  } ftoi_s1_t;

  // Align {1,man} into a fixed-point word with SIG_W fraction bits so that the
  // integer part, guard bit and sticky bits fall at fixed positions for -1 <= e <= 30.
  function automatic ftoi_s1_t ftoi_unpack(input logic [INT_W-1:0] f);
    ftoi_s1_t         r;
    logic [EXP_W-1:0] ex;
    logic [SIG_W-1:0] sig;
    logic [ALN_W-1:0] wide;
    logic [4:0]       sh;
    ex       = f[INT_W-2:MAN_W];
    sig      = {1'b1, f[MAN_W-1:0]};
    wide     = '0;
    sh       = '0;
    r.sign   = f[INT_W-1];
    r.mag    = '0;
    r.guard  = 1'b0;
    r.sticky = 1'b0;
    r.cls    = CLS_NORMAL;
    if (ex == '0) begin
      r.cls = CLS_ZERO;
    end else if (ex == EXP_INF) begin
      r.cls = CLS_SAT;
      // NaN saturates positive regardless of its sign bit.
      if (f[MAN_W-1:0] != '0) r.sign = 1'b0;
    end else if (ex >= EXP_BIAS + 8'd31) begin
      r.cls = CLS_SAT;
    end else if (ex < EXP_BIAS - 8'd1) begin
      r.cls = CLS_ZERO;
    end else begin
      sh       = 5'(ex - (EXP_BIAS - 8'd1));
      wide     = ALN_W'(sig) << sh;
      r.mag    = wide[ALN_W-1:SIG_W];
      r.guard  = wide[SIG_W-1];
      r.sticky = |wide[SIG_W-2:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ftoi_round.sv
// S2 combinational round, negate and saturate of an aligned float-to-int magnitude.
module ftoi_round
  import fpu_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic              sign,
  input  logic [INT_W-1:0]  mag,
  input  logic              guard,
  input  logic              sticky,
  input  logic [1:0]        cls,
  output logic [INT_W-1:0]  d_c
);

  logic             inc;
  logic [INT_W-1:0] rmag;

  // Magnitude never exceeds 2^31-1 for e <= 30, so the increment cannot overflow.
  always_comb begin
    inc  = 1'b0;
    rmag = '0;
    d_c  = '0;
    if (ROUND_NEAREST) inc = guard && (sticky || mag[0]);
    rmag = mag + INT_W'(inc);
    case (cls)
      CLS_NORMAL: d_c = (sign && (rmag != '0)) ? (~rmag + INT_W'(1)) : rmag;
      CLS_SAT:    d_c = sign ? INT_MIN : INT_MAX;
      default:    d_c = '0;
    endcase
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage IEEE-754 single to int32 converter with valid/ready flow control.
module ftoi_pipe
  import fpu_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INT_W-1:0]  s,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INT_W-1:0]  d
);

  logic             s1_valid;
  ftoi_s1_t         s1_q;
  logic             s1_adv;
  logic [INT_W-1:0] d_c;

  assign s1_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s1_adv;

  // S1: unpack and align the accepted operand.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= ftoi_unpack(s);
    end
  end

  ftoi_round #(
    .ROUND_NEAREST (ROUND_NEAREST)
  ) u_round (
    .sign   (s1_q.sign),
    .mag    (s1_q.mag),
    .guard  (s1_q.guard),
    .sticky (s1_q.sticky),
    .cls    (s1_q.cls),
    .d_c    (d_c)
  );

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      d         <= '0;
    end else if (s1_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) d <= d_c;
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: both rounding modes side by side against a real-arithmetic reference.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        rdy_rn, ov_rn, rdy_tz, ov_tz;
  logic [31:0] d_rn, d_tz;

  int n_vec = 0;
  int n_chk = 0;
  int n_err = 0;
  logic [31:0] q_rn[$];
  logic [31:0] q_tz[$];

  always #5 clk = ~clk;

  ftoi_pipe #(.ROUND_NEAREST(1'b1)) u_rn (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy_rn), .s(s),
    .out_valid(ov_rn), .out_ready(out_ready), .d(d_rn)
  );

  ftoi_pipe #(.ROUND_NEAREST(1'b0)) u_tz (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy_tz), .s(s),
    .out_valid(ov_tz), .out_ready(out_ready), .d(d_tz)
  );

  function automatic logic [31:0] ref_ftoi(input logic [31:0] x, input bit rn);
    int     ex;
    real    mag, f, fr;
    longint q;
    ex = int'(x[30:23]);
    if (ex == 0) return 32'h0;
    if (ex == 255) return (x[22:0] != 0 || !x[31]) ? 32'h7FFF_FFFF : 32'h8000_0000;
    mag = (8388608.0 + real'(x[22:0])) * (2.0 ** (real'(ex) - 150.0));
    if (mag >= 2147483648.0) return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    f  = $floor(mag);
    fr = mag - f;
    q  = longint'(f);
    if (rn && (fr > 0.5 || (fr == 0.5 && q[0]))) q = q + 1;
    if (x[31]) q = -q;
    return q[31:0];
  endfunction

  function automatic logic [31:0] rnd_float();
    logic [31:0] m;
    logic [7:0]  e;
    int          k;
    int          c;
    c = int'($urandom_range(0, 9));
    m = $urandom;
    k = int'($urandom_range(0, 23));
    if ($urandom_range(0, 1) == 1) m = (m >> k) << k;
    case (c)
      0:       e = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
      1, 2:    e = 8'(124 + $urandom_range(0, 3));
      9:       e = 8'($urandom);
      default: e = 8'(127 + $urandom_range(0, 32));
    endcase
    if (c == 0 && $urandom_range(0, 1) == 1) m[22:0] = '0;
    return {m[31], e, m[22:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, score any output handshake, record any input handshake.
  task automatic cycle(input logic v, input logic [31:0] sv, input logic ordy, output bit acc);
    in_valid  = v;
    s         = sv;
    out_ready = ordy;
    #1;
    acc = v && rdy_rn;
    if (ov_rn && ordy) begin
      if (q_rn.size() == 0) chk("unexpected_out_rn", 32'(ov_rn), 32'd0);
      else chk("stream_rn", d_rn, q_rn.pop_front());
    end
    if (ov_tz && ordy) begin
      if (q_tz.size() == 0) chk("unexpected_out_tz", 32'(ov_tz), 32'd0);
      else chk("stream_tz", d_tz, q_tz.pop_front());
    end
    if (acc) begin
      q_rn.push_back(ref_ftoi(sv, 1'b1));
      q_tz.push_back(ref_ftoi(sv, 1'b0));
      n_vec++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic single(input logic [31:0] sv, input logic [31:0] e_rn, input logic [31:0] e_tz,
                        input string tag);
    bit acc;
    cycle(1'b1, sv, 1'b1, acc);
    chk({tag, "_accept"}, 32'(acc), 32'd1);
    chk({tag, "_lat1"}, 32'(ov_rn), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, acc);
    chk({tag, "_lat2"}, 32'(ov_rn), 32'd1);
    chk({tag, "_rn"}, d_rn, e_rn);
    chk({tag, "_tz"}, d_tz, e_tz);
    cycle(1'b0, 32'h0, 1'b1, acc);
    chk({tag, "_after"}, 32'(ov_rn), 32'd0);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 8 && (q_rn.size() != 0 || q_tz.size() != 0); i++)
      cycle(1'b0, 32'h0, 1'b1, acc);
    chk("drain_rn", 32'(q_rn.size()), 32'd0);
    chk("drain_tz", 32'(q_tz.size()), 32'd0);
  endtask

  typedef struct {
    logic [31:0] s;
    logic [31:0] rn;
    logic [31:0] tz;
  } vec_t;

  vec_t dir[] = '{
    '{32'h3FC0_0000, 32'h0000_0002, 32'h0000_0001},
    '{32'h4020_0000, 32'h0000_0002, 32'h0000_0002},
    '{32'hBFC0_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF},
    '{32'h3F00_0000, 32'h0000_0000, 32'h0000_0000},
    '{32'h3F40_0000, 32'h0000_0001, 32'h0000_0000},
    '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000},
    '{32'h4F00_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
    '{32'hCF00_0000, 32'h8000_0000, 32'h8000_0000},
    '{32'h7FC0_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
    '{32'hFF80_0000, 32'h8000_0000, 32'h8000_0000},
    '{32'hC070_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFD},
    '{32'h4EFF_FFFF, 32'h7FFF_FF80, 32'h7FFF_FF80},
    '{32'h4B00_0001, 32'h0080_0001, 32'h0080_0001},
    '{32'h3FFF_FFFF, 32'h0000_0002, 32'h0000_0001},
    '{32'hBF40_0000, 32'hFFFF_FFFF, 32'h0000_0000},
    '{32'h3E80_0000, 32'h0000_0000, 32'h0000_0000},
    '{32'h0040_0000, 32'h0000_0000, 32'h0000_0000},
    '{32'hFFC0_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          sent;
    logic [31:0] held;

    rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b0; s = '0;
    #1 rstn = 1'b0;
    #1;
    chk("reset_ov", 32'(ov_rn), 32'd0);
    chk("reset_d", d_rn, 32'd0);
    chk("reset_ready", 32'(rdy_rn), 32'd1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    foreach (dir[i]) single(dir[i].s, dir[i].rn, dir[i].tz, $sformatf("dir%0d", i));

    // Back-to-back stream with a 3-cycle consumer stall.
    sent = 0;
    held = '0;
    for (int t = 0; t < 40 && sent < 8; t++) begin
      cycle(1'b1, rnd_float(), !(t >= 3 && t < 6), acc);
      if (acc) sent++;
      if (t == 2) held = d_rn;
      if (t >= 3 && t < 6) begin
        chk("stall_ov", 32'(ov_rn), 32'd1);
        chk("stall_ready", 32'(rdy_rn), 32'd0);
        chk("stall_hold", d_rn, held);
      end
    end
    chk("stream_sent", 32'(sent), 32'd8);
    drain();

    // Random traffic with random backpressure.
    for (int t = 0; t < 400; t++)
      cycle($urandom_range(0, 3) != 0, rnd_float(), $urandom_range(0, 9) < 7, acc);
    drain();

    // Reset with two operands in flight.
    cycle(1'b1, 32'h4040_0000, 1'b0, acc);
    cycle(1'b1, 32'hC0A0_0000, 1'b0, acc);
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midrst_ov", 32'(ov_rn), 32'd0);
    chk("midrst_d", d_rn, 32'd0);
    chk("midrst_ready", 32'(rdy_rn), 32'd1);
    q_rn.delete();
    q_tz.delete();
    @(posedge clk);
    #1;
    chk("midrst_hold_ov", 32'(ov_tz), 32'd0);
    rstn = 1'b1;
    single(32'h4020_0000, 32'h0000_0002, 32'h0000_0002, "post_rst");
    for (int t = 0; t < 4; t++) cycle(1'b0, 32'h0, 1'b1, acc);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
